cop_bus_chain: RTL and testbench

COP_BUS_CHAIN -- requirements
Module: cop_bus_chain

---
 rtl/cop_bus_chain.sv | 112 +++++++++++
 tb/tb_cop_bus_chain.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cop_bus_chain.sv
// cop_bus_chain: coprocessor read-data FIFO spliced into the up/down data bus chain; optional parity storage via COP_BUS_CHAIN_PARITY_EN.
// Latency: accepted word drives the next cycle when empty and not halted; ACK is withheld when full without a same-cycle pop, under SEN, and in reset.
module cop_bus_chain #(
    parameter int DATA_W = 32,
    parameter int N_COP  = 4,
    parameter int DEPTH  = 4
) (
    input  logic                      SYSCLK,
    input  logic                      RESET1N,
    input  logic                      SEN,
    input  logic                      HALT,
    input  logic                      MEMOP,
    input  logic [N_COP-1:0]          REQ,
    input  logic [N_COP*DATA_W-1:0]   CRDDATA,
    output logic [N_COP-1:0]          ACK,
    input  logic [DATA_W-1:0]         DBUSUPIN,
    input  logic [DATA_W-1:0]         DBUSDOWNIN,
    output logic [DATA_W-1:0]         DBUSUPOUT,
    output logic [DATA_W-1:0]         DBUSDOWNOUT,
    output logic [DATA_W-1:0]         DBUSCOPIN,
    output logic                      DRVVALID,
    output logic [$clog2(DEPTH):0]    COUNT,
    output logic                      DBUSPAROUT
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW:0]       r_count;

    logic              w_pop;
    logic              w_push;
    logic              w_space;
    logic [N_COP-1:0]  w_req_low;
    logic [N_COP-1:0]  w_ack;
    logic [DATA_W-1:0] w_push_dat;
    logic [DATA_W-1:0] w_head;

    assign w_pop     = !SEN && !HALT && (r_count != '0);
    assign w_space   = (r_count < DEPTH_C) || w_pop;
    // Isolates the lowest set request bit: fixed priority, slot 0 highest.
    assign w_req_low = REQ & (~REQ + N_COP'(1));
    assign w_ack     = (RESET1N && !SEN && w_space) ? w_req_low : '0;
    assign w_push    = |w_ack;
    assign w_head    = r_mem[r_rd_ptr];

    always_comb begin
        w_push_dat = '0;
        for (int k = 0; k < N_COP; k++) begin
            if (w_ack[k]) begin
                w_push_dat = w_push_dat | CRDDATA[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge SYSCLK or negedge RESET1N) begin
        if (!RESET1N) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge SYSCLK or negedge RESET1N) begin
        if (!RESET1N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_dat;
        end
    end

`ifdef COP_BUS_CHAIN_PARITY_EN
    logic [DEPTH-1:0] r_par;

    always_ff @(posedge SYSCLK or negedge RESET1N) begin
        if (!RESET1N) begin
            r_par <= '0;
        end else if (w_push) begin
            r_par[r_wr_ptr] <= ^w_push_dat;
        end
    end

    assign DBUSPAROUT = w_pop ? r_par[r_rd_ptr] : 1'b0;
`else
    assign DBUSPAROUT = 1'b0;
`endif

    assign ACK         = w_ack;
    assign COUNT       = r_count;
    assign DRVVALID    = w_pop;
    assign DBUSUPOUT   = w_pop ? w_head : DBUSUPIN;
    assign DBUSDOWNOUT = w_pop ? w_head : DBUSDOWNIN;
    assign DBUSCOPIN   = (MEMOP || HALT) ? DBUSUPIN : DBUSDOWNIN;

endmodule

// File: tb/tb_cop_bus_chain.sv
// Bench for cop_bus_chain: scenario tasks plus a free-running scoreboard monitor on the falling edge.
module tb_cop_bus_chain;

    localparam int DATA_W = 32;
    localparam int N_COP  = 4;
    localparam int DEPTH  = 4;

    logic                    SYSCLK = 1'b0;
    logic                    RESET1N = 1'b0;
    logic                    SEN = 1'b0;
    logic                    HALT = 1'b0;
    logic                    MEMOP = 1'b0;
    logic [N_COP-1:0]        REQ = '0;
    logic [N_COP*DATA_W-1:0] CRDDATA = '0;
    logic [N_COP-1:0]        ACK;
    logic [DATA_W-1:0]       DBUSUPIN = '0;
    logic [DATA_W-1:0]       DBUSDOWNIN = '0;
    logic [DATA_W-1:0]       DBUSUPOUT;
    logic [DATA_W-1:0]       DBUSDOWNOUT;
    logic [DATA_W-1:0]       DBUSCOPIN;
    logic                    DRVVALID;
    logic [$clog2(DEPTH):0]  COUNT;
    logic                    DBUSPAROUT;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] sb [$];

    cop_bus_chain #(.DATA_W(DATA_W), .N_COP(N_COP), .DEPTH(DEPTH)) dut (
        .SYSCLK(SYSCLK), .RESET1N(RESET1N), .SEN(SEN), .HALT(HALT), .MEMOP(MEMOP),
        .REQ(REQ), .CRDDATA(CRDDATA), .ACK(ACK),
        .DBUSUPIN(DBUSUPIN), .DBUSDOWNIN(DBUSDOWNIN),
        .DBUSUPOUT(DBUSUPOUT), .DBUSDOWNOUT(DBUSDOWNOUT), .DBUSCOPIN(DBUSCOPIN),
        .DRVVALID(DRVVALID), .COUNT(COUNT), .DBUSPAROUT(DBUSPAROUT)
    );

    always #5 SYSCLK = ~SYSCLK;

    function automatic logic exp_par(input logic [DATA_W-1:0] w);
`ifdef COP_BUS_CHAIN_PARITY_EN
        return ^w;
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge RESET1N) sb.delete();

    // Reference model: queue occupancy decides pop and acceptance each cycle.
    always @(negedge SYSCLK) begin
        if (RESET1N) begin
            int sz;
            logic exp_pop;
            logic [N_COP-1:0] exp_ack;
            logic [DATA_W-1:0] w;
            sz = sb.size();
            exp_pop = !SEN && !HALT && (sz != 0);
            n_checks++;
            if (int'(COUNT) != sz) begin
                n_fail++; $display("FAIL mon_count: got %0d want %0d", COUNT, sz);
            end
            n_checks++;
            if (DRVVALID !== exp_pop) begin
                n_fail++; $display("FAIL mon_drvvalid: got %b want %b", DRVVALID, exp_pop);
            end
            n_checks++;
            if (DBUSCOPIN !== ((MEMOP || HALT) ? DBUSUPIN : DBUSDOWNIN)) begin
                n_fail++; $display("FAIL mon_copin: got %h", DBUSCOPIN);
            end
            if (exp_pop) begin
                w = sb.pop_front();
                n_checks++;
                if (DBUSUPOUT !== w || DBUSDOWNOUT !== w || DBUSPAROUT !== exp_par(w)) begin
                    n_fail++;
                    $display("FAIL mon_drive: up %h down %h par %b want %h par %b",
                             DBUSUPOUT, DBUSDOWNOUT, DBUSPAROUT, w, exp_par(w));
                end
            end else begin
                n_checks++;
                if (DBUSUPOUT !== DBUSUPIN || DBUSDOWNOUT !== DBUSDOWNIN || DBUSPAROUT !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mon_passthru: up %h down %h par %b want %h %h 0",
                             DBUSUPOUT, DBUSDOWNOUT, DBUSPAROUT, DBUSUPIN, DBUSDOWNIN);
                end
            end
            exp_ack = '0;
            if (!SEN && (sz < DEPTH || exp_pop)) begin
                for (int k = N_COP - 1; k >= 0; k--) begin
                    if (REQ[k]) exp_ack = N_COP'(1) << k;
                end
            end
            n_checks++;
            if (ACK !== exp_ack) begin
                n_fail++; $display("FAIL mon_ack: got %b want %b", ACK, exp_ack);
            end
            for (int k = 0; k < N_COP; k++) begin
                if (exp_ack[k]) sb.push_back(CRDDATA[k*DATA_W +: DATA_W]);
            end
        end
    end

    task automatic step();
        @(posedge SYSCLK); #1;
    endtask

    task automatic push_wait(input int slot, input logic [DATA_W-1:0] d, output bit ok);
        REQ[slot] = 1'b1;
        CRDDATA[slot*DATA_W +: DATA_W] = d;
        ok = 1'b0;
        for (int c = 0; c < 10 && !ok; c++) begin
            @(negedge SYSCLK);
            if (ACK[slot]) ok = 1'b1;
            step();
        end
        REQ[slot] = 1'b0;
    endtask

    task automatic test_reset();
        RESET1N = 1'b0; REQ = 4'b0001; DBUSUPIN = 32'h1111_0000; DBUSDOWNIN = 32'h2222_0000;
        repeat (2) @(posedge SYSCLK);
        @(negedge SYSCLK);
        n_checks++;
        if (COUNT !== '0 || ACK !== '0 || DRVVALID !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: count %0d ack %b drv %b want 0 0 0", COUNT, ACK, DRVVALID);
        end
        n_checks++;
        if (DBUSUPOUT !== DBUSUPIN || DBUSDOWNOUT !== DBUSDOWNIN) begin
            n_fail++; $display("FAIL reset_passthru: up %h down %h", DBUSUPOUT, DBUSDOWNOUT);
        end
        step();
        REQ = '0; RESET1N = 1'b1;
        step();
    endtask

    task automatic test_single();
        REQ = 4'b0001; CRDDATA[31:0] = 32'hDEAD_BEEF;
        @(negedge SYSCLK);
        n_checks++;
        if (ACK !== 4'b0001) begin
            n_fail++; $display("FAIL single_ack: got %b want 0001", ACK);
        end
        step();
        REQ = '0;
        @(negedge SYSCLK);
        n_checks++;
        if (DRVVALID !== 1'b1 || DBUSUPOUT !== 32'hDEAD_BEEF || DBUSDOWNOUT !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL single_drive: drv %b up %h down %h want 1 deadbeef", DRVVALID, DBUSUPOUT, DBUSDOWNOUT);
        end
        step();
        @(negedge SYSCLK);
        n_checks++;
        if (COUNT !== '0) begin
            n_fail++; $display("FAIL single_count: got %0d want 0", COUNT);
        end
        step();
    endtask

    task automatic test_priority();
        CRDDATA[1*DATA_W +: DATA_W] = 32'hA1A1_0001;
        CRDDATA[2*DATA_W +: DATA_W] = 32'hB2B2_0002;
        REQ = 4'b0110;
        @(negedge SYSCLK);
        n_checks++;
        if (ACK !== 4'b0010) begin
            n_fail++; $display("FAIL prio_first: got %b want 0010", ACK);
        end
        step();
        REQ = 4'b0100;
        @(negedge SYSCLK);
        n_checks++;
        if (ACK !== 4'b0100 || DBUSUPOUT !== 32'hA1A1_0001) begin
            n_fail++; $display("FAIL prio_second: ack %b up %h want 0100 a1a10001", ACK, DBUSUPOUT);
        end
        step();
        REQ = '0;
        @(negedge SYSCLK);
        n_checks++;
        if (DRVVALID !== 1'b1 || DBUSDOWNOUT !== 32'hB2B2_0002) begin
            n_fail++; $display("FAIL prio_order: drv %b down %h want 1 b2b20002", DRVVALID, DBUSDOWNOUT);
        end
        step();
    endtask

    task automatic test_halt();
        bit ok;
        HALT = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_wait(0, 32'hC0DE_0000 + DATA_W'(i), ok);
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL halt_push%0d: no ACK within budget, want ACK", i);
            end
        end
        REQ[0] = 1'b1; CRDDATA[31:0] = 32'hC0DE_0004;
        for (int c = 0; c < 3; c++) begin
            @(negedge SYSCLK);
            n_checks++;
            if (ACK !== '0 || COUNT !== 3'd4) begin
                n_fail++; $display("FAIL halt_full: ack %b count %0d want 0000 4", ACK, COUNT);
            end
            step();
        end
        HALT = 1'b0;
        @(negedge SYSCLK);
        n_checks++;
        if (ACK !== 4'b0001 || DRVVALID !== 1'b1) begin
            n_fail++; $display("FAIL halt_release: ack %b drv %b want 0001 1", ACK, DRVVALID);
        end
        step();
        REQ = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge SYSCLK);
            n_checks++;
            if (COUNT > 3'd4) begin
                n_fail++; $display("FAIL halt_bound: count %0d want <= 4", COUNT);
            end
            step();
        end
    endtask

    task automatic test_memop();
        DBUSUPIN = 32'h1; DBUSDOWNIN = 32'h2; MEMOP = 1'b1; HALT = 1'b0;
        #1;
        n_checks++;
        if (DBUSCOPIN !== 32'h1) begin
            n_fail++; $display("FAIL memop_up: got %h want 1", DBUSCOPIN);
        end
        MEMOP = 1'b0;
        #1;
        n_checks++;
        if (DBUSCOPIN !== 32'h2) begin
            n_fail++; $display("FAIL memop_down: got %h want 2", DBUSCOPIN);
        end
        step();
    endtask

    task automatic test_scan_reset();
        bit ok;
        HALT = 1'b1;
        push_wait(3, 32'h5CA0_0001, ok);
        push_wait(3, 32'h5CA0_0002, ok);
        HALT = 1'b0; SEN = 1'b1; REQ = 4'b0001; DBUSUPIN = 32'h7777_0001; DBUSDOWNIN = 32'h8888_0002;
        for (int c = 0; c < 3; c++) begin
            @(negedge SYSCLK);
            n_checks++;
            if (ACK !== '0 || DRVVALID !== 1'b0 || DBUSUPOUT !== 32'h7777_0001 ||
                DBUSDOWNOUT !== 32'h8888_0002 || COUNT !== 3'd2) begin
                n_fail++; $display("FAIL scan_hold: ack %b drv %b up %h down %h count %0d",
                                   ACK, DRVVALID, DBUSUPOUT, DBUSDOWNOUT, COUNT);
            end
            step();
        end
        SEN = 1'b0; REQ = '0;
        @(negedge SYSCLK);
        n_checks++;
        if (DRVVALID !== 1'b1 || DBUSUPOUT !== 32'h5CA0_0001) begin
            n_fail++; $display("FAIL scan_drain0: drv %b up %h want 1 5ca00001", DRVVALID, DBUSUPOUT);
        end
        step();
        @(negedge SYSCLK);
        n_checks++;
        if (DRVVALID !== 1'b1 || DBUSUPOUT !== 32'h5CA0_0002) begin
            n_fail++; $display("FAIL scan_drain1: drv %b up %h want 1 5ca00002", DRVVALID, DBUSUPOUT);
        end
        step();
        HALT = 1'b1;
        for (int i = 0; i < 3; i++) push_wait(2, 32'h9900_0000 + DATA_W'(i), ok);
        @(negedge SYSCLK);
        n_checks++;
        if (COUNT !== 3'd3) begin
            n_fail++; $display("FAIL rst_pre: count %0d want 3", COUNT);
        end
        #2 RESET1N = 1'b0;
        #1;
        n_checks++;
        if (COUNT !== '0 || ACK !== '0 || DRVVALID !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid: count %0d ack %b drv %b want 0 0 0", COUNT, ACK, DRVVALID);
        end
        step();
        RESET1N = 1'b1; HALT = 1'b0;
        step();
    endtask

    task automatic test_parity();
        bit ok;
        HALT = 1'b1;
        push_wait(0, 32'h0000_0001, ok);
        push_wait(0, 32'h0000_0003, ok);
        HALT = 1'b0;
        @(negedge SYSCLK);
        n_checks++;
        if (DRVVALID !== 1'b1 || DBUSPAROUT !== 1'b1) begin
            n_fail++; $display("FAIL parity_odd: drv %b par %b want 1 1", DRVVALID, DBUSPAROUT);
        end
        step();
        @(negedge SYSCLK);
        n_checks++;
        if (DRVVALID !== 1'b1 || DBUSPAROUT !== 1'b0) begin
            n_fail++; $display("FAIL parity_even: drv %b par %b want 1 0", DRVVALID, DBUSPAROUT);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [N_COP-1:0] a;
        for (int c = 0; c < 400; c++) begin
            @(negedge SYSCLK);
            a = ACK;
            step();
            REQ = REQ & ~a;
            for (int k = 0; k < N_COP; k++) begin
                if (!REQ[k] && $urandom_range(0, 2) == 0) begin
                    REQ[k] = 1'b1;
                    CRDDATA[k*DATA_W +: DATA_W] = $urandom();
                end
            end
            HALT = ($urandom_range(0, 3) == 0);
            SEN = ($urandom_range(0, 9) == 0);
            MEMOP = $urandom_range(0, 1) == 1;
            DBUSUPIN = $urandom();
            DBUSDOWNIN = $urandom();
        end
        REQ = '0; HALT = 1'b0; SEN = 1'b0;
        repeat (DEPTH + 4) step();
        @(negedge SYSCLK);
        n_checks++;
        if (COUNT !== '0 || sb.size() != 0) begin
            n_fail++; $display("FAIL b2b_drain: count %0d queue %0d want 0 0", COUNT, sb.size());
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_halt();
        test_memop();
        test_scan_reset();
`ifdef COP_BUS_CHAIN_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
